// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load reader.
// Detects a load in EX/MEM, runs a req/ready + rvalid read to data memory,
// stalls the pipeline while waiting, then aligns and extends the returned word
// for MEM/WB. Misaligned or illegal loads and slow memory are reported as pulses.
module mem_load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [31:0] instr_ex_mem,
    input  logic [31:0] ex_mem_output,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_ready,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        stall_mem,
    output logic        load_valid,
    output logic [4:0]  load_rd,
    output logic [31:0] load_data_final,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR_MIS,
        S_ERR_TO
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [1:0]    r_lane;
    logic [2:0]    r_f3;
    logic [4:0]    r_rd_lat;
    logic [4:0]    r_rd;
    logic [31:0]   r_data;
    logic          r_load_valid;
    logic          r_mis;
    logic          r_to;

    logic [6:0]    w_opcode;
    logic [2:0]    w_f3;
    logic          w_is_load;
    logic          w_f3_legal;
    logic          w_misalign;
    logic [CW-1:0] w_cnt_next;
    logic          w_timeout;
    logic          w_req_done;
    logic          w_wait_done;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;

    assign w_opcode   = instr_ex_mem[6:0];
    assign w_f3       = instr_ex_mem[14:12];
    // Gated by rst so every output reads 0 while reset is held.
    assign w_is_load  = !rst && ex_mem_valid && (w_opcode == 7'b0000011);
    assign w_cnt_next = r_cnt + CW'(1);
    assign w_timeout  = (w_cnt_next == CW'(TIMEOUT_CYCLES));
    assign w_req_done = (r_state == S_REQ) && mem_rd_ready && mem_rd_valid;
    assign w_wait_done = (r_state == S_WAIT) && mem_rd_valid;

    // Classify funct3 and alignment of the incoming load
    always_comb begin
        w_f3_legal = 1'b0;
        w_misalign = 1'b0;
        case (w_f3)
            3'b000, 3'b100: w_f3_legal = 1'b1;
            3'b001, 3'b101: begin
                w_f3_legal = 1'b1;
                w_misalign = ex_mem_output[0];
            end
            3'b010: begin
                w_f3_legal = 1'b1;
                w_misalign = (ex_mem_output[1:0] != 2'b00);
            end
            default: w_f3_legal = 1'b0;
        endcase
    end

    // Select the addressed lane of the returned word and extend it
    always_comb begin
        w_byte = mem_rd_data[{r_lane, 3'b000} +: 8];
        w_half = mem_rd_data[{r_lane[1], 4'b0000} +: 16];
        w_ext  = '0;
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = mem_rd_data;
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = '0;
        endcase
    end

    // Load FSM with registered request, result and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_lane       <= '0;
            r_f3         <= '0;
            r_rd_lat     <= '0;
            r_rd         <= '0;
            r_data       <= '0;
            r_load_valid <= 1'b0;
            r_mis        <= 1'b0;
            r_to         <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_mis        <= 1'b0;
            r_to         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_load) begin
                        if (!w_f3_legal || w_misalign) begin
                            r_mis   <= 1'b1;
                            r_state <= S_ERR_MIS;
                        end else begin
                            r_lane   <= ex_mem_output[1:0];
                            r_f3     <= w_f3;
                            r_rd_lat <= instr_ex_mem[11:7];
                            r_addr   <= {ex_mem_output[31:2], 2'b00};
                            r_cnt    <= '0;
                            r_req    <= 1'b1;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_next;
                    // Completion is tested before timeout so it wins on the last cycle.
                    if (w_req_done) begin
                        r_data       <= w_ext;
                        r_rd         <= r_rd_lat;
                        r_load_valid <= 1'b1;
                        r_req        <= 1'b0;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_to    <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_ERR_TO;
                    end else if (mem_rd_ready) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (w_wait_done) begin
                        r_data       <= w_ext;
                        r_rd         <= r_rd_lat;
                        r_load_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_to    <= 1'b1;
                        r_state <= S_ERR_TO;
                    end
                end
                S_DONE, S_ERR_MIS, S_ERR_TO: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_req      = r_req;
    assign mem_rd_addr     = r_addr;
    assign stall_mem       = (r_state == S_REQ) || (r_state == S_WAIT) ||
                             ((r_state == S_IDLE) && w_is_load);
    assign load_valid      = r_load_valid;
    assign load_rd         = r_rd;
    assign load_data_final = r_data;
    assign misalign_err    = r_mis;
    assign timeout_err     = r_to;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: table-driven load vectors plus hand-written corner sequences.
// Expected completions go into a scoreboard queue when a load is driven and are
// popped by a monitor whenever the unit emits a load/misalign/timeout pulse.
module tb_mem_load_unit;

    localparam int unsigned TO_CYC = 8;
    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_MIS  = 2'd1;
    localparam logic [1:0] K_TO   = 2'd2;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_valid = 1'b0;
    logic [31:0] instr_ex_mem = '0;
    logic [31:0] ex_mem_output = '0;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ready = 1'b0;
    logic        mem_rd_valid = 1'b0;
    logic [31:0] mem_rd_data = 32'hA5A5A5A5;
    logic        stall_mem;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [31:0] load_data_final;
    logic        misalign_err;
    logic        timeout_err;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] data;
        int unsigned rdy_dly;
        int unsigned val_dly;
        logic [1:0]  kind;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad = 0;

    mem_load_unit #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_mem_valid    (ex_mem_valid),
        .instr_ex_mem    (instr_ex_mem),
        .ex_mem_output   (ex_mem_output),
        .mem_rd_req      (mem_rd_req),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_ready    (mem_rd_ready),
        .mem_rd_valid    (mem_rd_valid),
        .mem_rd_data     (mem_rd_data),
        .stall_mem       (stall_mem),
        .load_valid      (load_valid),
        .load_rd         (load_rd),
        .load_data_final (load_data_final),
        .misalign_err    (misalign_err),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (!rst && (load_valid || misalign_err || timeout_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, load_valid, misalign_err, timeout_err}, 32'd0);
            end else begin
                m_e = sb.pop_front();
                case (m_e.kind)
                    K_LOAD: begin
                        chk("pulse_load", {29'd0, load_valid, misalign_err, timeout_err}, 32'd4);
                        chk("load_rd", {27'd0, load_rd}, {27'd0, m_e.rd});
                        chk("load_data", load_data_final, m_e.data);
                    end
                    K_MIS: chk("pulse_mis", {29'd0, load_valid, misalign_err, timeout_err}, 32'd2);
                    default: begin
                        chk("pulse_to", {29'd0, load_valid, misalign_err, timeout_err}, 32'd1);
                        chk("to_data", load_data_final, 32'd0);
                    end
                endcase
            end
        end
    end

    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        @(negedge clk);
        instr_ex_mem  = {17'd0, f3, rd, 7'b0000011};
        ex_mem_output = addr;
        ex_mem_valid  = 1'b1;
        #1 chk("stall_detect", {31'd0, stall_mem}, 32'd1);
    endtask

    task automatic run_load(input vec_t v);
        exp_t e;
        e.kind = v.kind;
        e.rd   = v.rd;
        e.data = v.exp;
        sb.push_back(e);
        drive_load(v.f3, v.addr, v.rd);
        if (v.kind == K_MIS) begin
            @(negedge clk);
            chk("mis_req", {31'd0, mem_rd_req}, 32'd0);
            chk("mis_stall", {31'd0, stall_mem}, 32'd0);
            ex_mem_valid = 1'b0;
            @(negedge clk);
            chk("mis_req_after", {31'd0, mem_rd_req}, 32'd0);
        end else begin
            for (int unsigned i = 0; i <= v.rdy_dly; i++) begin
                @(negedge clk);
                chk("req_high", {31'd0, mem_rd_req}, 32'd1);
                chk("req_addr", mem_rd_addr, {v.addr[31:2], 2'b00});
                chk("req_stall", {31'd0, stall_mem}, 32'd1);
                mem_rd_ready = (i == v.rdy_dly);
                mem_rd_valid = (i == v.rdy_dly) && (v.val_dly == 0);
                mem_rd_data  = mem_rd_valid ? v.data : 32'hA5A5A5A5;
            end
            for (int unsigned j = 1; j <= v.val_dly; j++) begin
                @(negedge clk);
                mem_rd_ready = 1'b0;
                chk("wait_req", {31'd0, mem_rd_req}, 32'd0);
                chk("wait_stall", {31'd0, stall_mem}, 32'd1);
                mem_rd_valid = (j == v.val_dly);
                mem_rd_data  = mem_rd_valid ? v.data : 32'hA5A5A5A5;
            end
            @(negedge clk);
            mem_rd_ready = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_data  = 32'hA5A5A5A5;
            chk("done_stall", {31'd0, stall_mem}, 32'd0);
            ex_mem_valid = 1'b0;
            @(negedge clk);
            chk("data_hold", load_data_final, v.exp);
            chk("valid_one_cycle", {31'd0, load_valid}, 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        //           f3      addr        rd     data          rdy ver kind    expected
        vecs[0]  = '{3'b010, 32'h100, 5'd5,  32'hDEADBEEF, 0, 2, K_LOAD, 32'hDEADBEEF};
        vecs[1]  = '{3'b000, 32'h103, 5'd6,  32'h80FF1234, 1, 0, K_LOAD, 32'hFFFFFF80};
        vecs[2]  = '{3'b100, 32'h103, 5'd7,  32'h80FF1234, 0, 1, K_LOAD, 32'h00000080};
        vecs[3]  = '{3'b001, 32'h102, 5'd8,  32'h80015678, 2, 1, K_LOAD, 32'hFFFF8001};
        vecs[4]  = '{3'b101, 32'h101, 5'd9,  32'h0,        0, 0, K_MIS,  32'h0};
        vecs[5]  = '{3'b011, 32'h200, 5'd10, 32'h0,        0, 0, K_MIS,  32'h0};
        vecs[6]  = '{3'b010, 32'h102, 5'd11, 32'h0,        0, 0, K_MIS,  32'h0};
        vecs[7]  = '{3'b001, 32'h103, 5'd12, 32'h0,        0, 0, K_MIS,  32'h0};
        vecs[8]  = '{3'b110, 32'h204, 5'd2,  32'h0,        0, 0, K_MIS,  32'h0};
        vecs[9]  = '{3'b101, 32'h102, 5'd13, 32'h80015678, 0, 0, K_LOAD, 32'h00008001};
        vecs[10] = '{3'b001, 32'h100, 5'd14, 32'h1234F00D, 0, 3, K_LOAD, 32'hFFFFF00D};
        vecs[11] = '{3'b000, 32'h101, 5'd15, 32'h0000AB00, 3, 0, K_LOAD, 32'hFFFFFFAB};
        vecs[12] = '{3'b010, 32'h1FC, 5'd31, 32'hCAFEF00D, 7, 0, K_LOAD, 32'hCAFEF00D};
        vecs[13] = '{3'b100, 32'h100, 5'd1,  32'h1234567F, 0, 7, K_LOAD, 32'h0000007F};
        vecs[14] = '{3'b111, 32'h300, 5'd4,  32'h0,        0, 0, K_MIS,  32'h0};
        vecs[15] = '{3'b010, 32'h000, 5'd0,  32'h13579BDF, 0, 0, K_LOAD, 32'h13579BDF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, mem_rd_req}, 32'd0);
        chk("rst_addr", mem_rd_addr, 32'd0);
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_pulses", {29'd0, load_valid, misalign_err, timeout_err}, 32'd0);
        chk("rst_rd", {27'd0, load_rd}, 32'd0);
        chk("rst_data", load_data_final, 32'd0);
        rst = 1'b0;

        // Non-load instruction and invalid slot: no stall, no request
        @(negedge clk);
        instr_ex_mem = {17'd0, 3'b010, 5'd3, 7'b0110011};
        ex_mem_valid = 1'b1;
        #1 chk("nonload_stall", {31'd0, stall_mem}, 32'd0);
        @(negedge clk);
        chk("nonload_req", {31'd0, mem_rd_req}, 32'd0);
        instr_ex_mem = {17'd0, 3'b010, 5'd3, 7'b0000011};
        ex_mem_valid = 1'b0;
        #1 chk("invalid_stall", {31'd0, stall_mem}, 32'd0);
        @(negedge clk);
        chk("invalid_req", {31'd0, mem_rd_req}, 32'd0);

        for (int k = 0; k < NV; k++) run_load(vecs[k]);

        // Timeout: ready never comes; abandoned after TO_CYC cycles in REQ
        sb.push_back('{K_TO, 5'd9, 32'd0});
        drive_load(3'b010, 32'h300, 5'd9);
        for (int unsigned i = 0; i < TO_CYC; i++) begin
            @(negedge clk);
            chk("to_req_held", {31'd0, mem_rd_req}, 32'd1);
        end
        @(negedge clk);
        chk("to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("to_no_valid", {31'd0, load_valid}, 32'd0);
        chk("to_clear_data", load_data_final, 32'd0);
        chk("to_stall", {31'd0, stall_mem}, 32'd0);
        chk("to_req", {31'd0, mem_rd_req}, 32'd0);
        ex_mem_valid = 1'b0;
        @(negedge clk);
        chk("to_one_cycle", {31'd0, timeout_err}, 32'd0);

        // Reset during WAIT: access abandoned, late rvalid ignored
        drive_load(3'b010, 32'h400, 5'd3);
        @(negedge clk);
        mem_rd_ready = 1'b1;
        @(negedge clk);
        mem_rd_ready = 1'b0;
        chk("rw_wait_stall", {31'd0, stall_mem}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rw_req", {31'd0, mem_rd_req}, 32'd0);
        chk("rw_stall", {31'd0, stall_mem}, 32'd0);
        ex_mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'h11111111;
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_no_valid", {31'd0, load_valid}, 32'd0);
            chk("rw_no_req", {31'd0, mem_rd_req}, 32'd0);
        end

        // ready and rvalid together in REQ: minimum latency
        v = '{3'b010, 32'h500, 5'd17, 32'h00000042, 0, 0, K_LOAD, 32'h00000042};
        run_load(v);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
